// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port between NUM_REQ
//   producers. Grants, wr_en and data are registered. Issue is throttled on
//   full/almostfull so the FIFO is never written while full. Every issued
//   write has its wr_ack checked one cycle later. A missing ack raises a
//   sticky error that records the producer id. Acked writes are counted.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   arb_en_i              1 = new grants allowed
//   req_i, req_data_i     per-producer request and word
//                         (producer i's word is [i*FIFO_WIDTH +: FIFO_WIDTH])
//   gnt_o                 one-hot, one-cycle grant pulse
//   fifo_full_i           FIFO full status
//   fifo_almostfull_i     FIFO almostfull status
//   fifo_wr_ack_i         FIFO write acknowledge
//   fifo_wr_en_o          drives the FIFO wr_en
//   fifo_data_o           drives the FIFO data_in
//   err_clr_i             clears the sticky ack error
//   ack_err_o, err_id_o   sticky ack error and the first failing producer
//   wr_total_o            count of acknowledged writes (wraps)
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            arb_en_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    input  logic                            fifo_full_i,
    input  logic                            fifo_almostfull_i,
    input  logic                            fifo_wr_ack_i,
    output logic                            fifo_wr_en_o,
    output logic [FIFO_WIDTH-1:0]           fifo_data_o,
    input  logic                            err_clr_i,
    output logic                            ack_err_o,
    output logic [ID_W-1:0]                 err_id_o,
    output logic [15:0]                     wr_total_o
);

    // Word view of the flat data bus; word i sits at [i*FIFO_WIDTH +: FIFO_WIDTH].
    logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_words;
    assign req_words = req_data_i;

    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       port_id_q, port_id_d;   // producer of the write on the port
    logic                  pipe_vld_q;             // ack expected this cycle
    logic [ID_W-1:0]       pipe_id_q;
    logic                  ack_err_q, ack_err_d;
    logic [ID_W-1:0]       err_id_q, err_id_d;
    logic [15:0]           wr_total_q, wr_total_d;

    logic [NUM_REQ-1:0]    elig;
    logic                  issue;
    logic                  found;
    logic [ID_W-1:0]       win_id;
    logic [ID_W:0]         sum;
    logic                  ack_fail;

    // A request already granted this cycle is masked: its word is on the
    // port now and the producer has not yet had a chance to advance it.
    assign elig = req_i & ~gnt_q;

    // The write on the port is not yet reflected in the FIFO count, so
    // almostfull plus an outstanding write is treated as full.
    assign issue = arb_en_i & (|elig) & ~fifo_full_i & ~(wr_en_q & fifo_almostfull_i);

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!found && elig[sum[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        rr_ptr_d  = rr_ptr_q;
        port_id_d = port_id_q;
        if (issue) begin
            gnt_d     = NUM_REQ'(1) << win_id;
            wr_en_d   = 1'b1;
            data_d    = req_words[win_id];
            port_id_d = win_id;
            rr_ptr_d  = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
        end
    end

    // Ack check. A new failure overrides a same-cycle clear.
    assign ack_fail = pipe_vld_q & ~fifo_wr_ack_i;

    always_comb begin
        ack_err_d  = ack_err_q;
        err_id_d   = err_id_q;
        wr_total_d = wr_total_q;
        if (pipe_vld_q && fifo_wr_ack_i)
            wr_total_d = wr_total_q + 16'd1;
        if (ack_fail && (!ack_err_q || err_clr_i)) begin
            ack_err_d = 1'b1;
            err_id_d  = pipe_id_q;
        end else if (err_clr_i) begin
            ack_err_d = 1'b0;
            err_id_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q      <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            rr_ptr_q   <= '0;
            port_id_q  <= '0;
            pipe_vld_q <= 1'b0;
            pipe_id_q  <= '0;
            ack_err_q  <= 1'b0;
            err_id_q   <= '0;
            wr_total_q <= '0;
        end else begin
            gnt_q      <= gnt_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            rr_ptr_q   <= rr_ptr_d;
            port_id_q  <= port_id_d;
            pipe_vld_q <= wr_en_q;
            pipe_id_q  <= port_id_q;
            ack_err_q  <= ack_err_d;
            err_id_q   <= err_id_d;
            wr_total_q <= wr_total_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign fifo_wr_en_o = wr_en_q;
    assign fifo_data_o  = data_q;
    assign ack_err_o    = ack_err_q;
    assign err_id_o     = err_id_q;
    assign wr_total_o   = wr_total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 FIFO model on the write
// side (full/almostfull/wr_ack, with an option to withhold the ack).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arb_en = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] pdata [4];
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        full, afull, wr_ack, wr_en;
    logic [15:0] fdata;
    logic        err_clr = 1'b0;
    logic        ack_err;
    logic [1:0]  err_id;
    logic [15:0] wr_total;

    int checks = 0;
    int failures = 0;

    // FIFO model
    logic [15:0] q [$];
    int          cnt = 0;
    int          ovf = 0;
    logic        nack = 1'b0;
    logic        rd = 1'b0;
    logic        fclr = 1'b0;
    logic        ack_r = 1'b0;

    // Invariant monitor
    int inv = 0;
    int gnt_cnt = 0;
    int base;

    always #5 clk = ~clk;

    assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
    assign full     = (cnt == 8);
    assign afull    = (cnt == 7);
    assign wr_ack   = ack_r;

    fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .ID_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .arb_en_i(arb_en), .req_i(req),
        .req_data_i(req_data), .gnt_o(gnt), .fifo_full_i(full),
        .fifo_almostfull_i(afull), .fifo_wr_ack_i(wr_ack),
        .fifo_wr_en_o(wr_en), .fifo_data_o(fdata), .err_clr_i(err_clr),
        .ack_err_o(ack_err), .err_id_o(err_id), .wr_total_o(wr_total)
    );

    always @(posedge clk) begin
        if (fclr) begin
            q.delete();
            cnt   <= 0;
            ack_r <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            if (wr_en) begin
                if (q.size() < 8) begin
                    q.push_back(fdata);
                    ack_r <= ~nack;
                end else begin
                    ovf++;
                end
            end
            if (rd && q.size() > 0) void'(q.pop_front());
            cnt <= q.size();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (|gnt) gnt_cnt++;
            if (wr_en && full) inv++;
            if ((gnt & (gnt - 4'd1)) != 4'd0) inv++;
            if (wr_en != (|gnt)) inv++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; producers that saw a grant present their next word.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (gnt[i]) pdata[i] = pdata[i] + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fclr = 1'b1; req = '0; arb_en = 1'b0;
        nack = 1'b0; rd = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0; fclr = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'd0);
        chk({tag, "_wren"},  32'(wr_en), 32'd0);
        chk({tag, "_data"},  32'(fdata), 32'd0);
        chk({tag, "_err"},   32'(ack_err), 32'd0);
        chk({tag, "_errid"}, 32'(err_id), 32'd0);
        chk({tag, "_total"}, 32'(wr_total), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pdata[i] = '0;

        // Reset state
        do_reset();
        chk_idle("rst");

        // Single request: grant next cycle, count two cycles after grant
        arb_en = 1'b1;
        pdata[0] = 16'hA5A5; req = 4'b0001;
        tick();
        chk("t1_gnt",  32'(gnt), 32'h1);
        chk("t1_wren", 32'(wr_en), 32'd1);
        chk("t1_data", 32'(fdata), 32'hA5A5);
        req = 4'b0000;
        tick();
        chk("t1_gnt_off", 32'(gnt), 32'h0);
        chk("t1_total0",  32'(wr_total), 32'd0);
        tick();
        chk("t1_total1",  32'(wr_total), 32'd1);

        // All four requesting: 0,1,2,3,0,... back-to-back; FIFO fills at 8
        do_reset();
        arb_en = 1'b1;
        for (int i = 0; i < 4; i++) pdata[i] = 16'(i << 12);
        base = gnt_cnt;
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            tick();
            chk($sformatf("rr_gnt%0d", n),  32'(gnt), 32'(1 << (n % 4)));
            chk($sformatf("rr_data%0d", n), 32'(fdata), 32'(((n % 4) << 12) | (n / 4)));
        end
        for (int n = 0; n < 6; n++) tick();
        chk("full_grants", 32'(gnt_cnt - base), 32'd8);
        chk("full_qsize",  32'(q.size()), 32'd8);
        for (int n = 0; n < 8; n++)
            chk($sformatf("order%0d", n), 32'(q[n]), 32'(((n % 4) << 12) | (n / 4)));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        chk("read_one_grant", 32'(gnt_cnt - base), 32'd9);
        chk("read_one_data",  32'(q[7]), 32'h0002);
        req = 4'b0000;

        // Ack errors: first failure sticks, later one ignored, clear
        do_reset();
        arb_en = 1'b1;
        req = 4'b0100;
        tick();
        chk("e_gnt2", 32'(gnt), 32'h4);
        req = 4'b0000; nack = 1'b1;
        tick();
        nack = 1'b0;
        chk("e_err_early", 32'(ack_err), 32'd0);
        tick();
        chk("e_err1", 32'(ack_err), 32'd1);
        chk("e_id2",  32'(err_id), 32'd2);
        req = 4'b0010;
        tick();
        req = 4'b0000; nack = 1'b1;
        tick();
        nack = 1'b0;
        tick();
        chk("e_err_keep", 32'(ack_err), 32'd1);
        chk("e_id_keep",  32'(err_id), 32'd2);
        // failure coincident with clear: failure wins with the new id
        req = 4'b1000;
        tick();
        req = 4'b0000; nack = 1'b1;
        tick();
        nack = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("e_win_err", 32'(ack_err), 32'd1);
        chk("e_win_id",  32'(err_id), 32'd3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("e_clr_err", 32'(ack_err), 32'd0);
        chk("e_clr_id",  32'(err_id), 32'd0);
        chk("e_total",   32'(wr_total), 32'd0);

        // arb_en dropped while a grant is on the port
        do_reset();
        arb_en = 1'b1;
        req = 4'b0011;
        tick();
        chk("en_gnt0", 32'(gnt), 32'h1);
        arb_en = 1'b0; req = 4'b0010;
        tick();
        chk("en_gnt_off", 32'(gnt), 32'h0);
        tick();
        chk("en_total", 32'(wr_total), 32'd1);
        tick(); tick();
        chk("en_still_off", 32'(gnt), 32'h0);
        arb_en = 1'b1;
        tick();
        chk("en_gnt1", 32'(gnt), 32'h2);
        req = 4'b0000;

        // Reset mid-stream
        do_reset();
        arb_en = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        chk("mid_wren", 32'(wr_en), 32'd1);
        chk("mid_gnt",  32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        chk_idle("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        chk("mid_first_gnt", 32'(gnt), 32'h1);
        chk("mid_total",     32'(wr_total), 32'd0);
        req = 4'b0000;
        tick(); tick();

        chk("invariants", 32'(inv), 32'd0);
        chk("overflow",   32'(ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
